// File: rtl/axis_unpack_keepdec.sv
// rtl/axis_unpack_keepdec.sv - keep-mask legality check and lane count for axis_unpack
module axis_unpack_keepdec #(
    parameter int RATIO = 4,
    parameter int NW    = $clog2(RATIO + 1)
) (
    input  logic [RATIO-1:0] i_keep,
    output logic             o_legal,
    output logic [NW-1:0]    o_nlanes
);

    logic [RATIO-1:0] w_keep_plus1;
    logic [NW-1:0]    w_count;

    assign w_keep_plus1 = i_keep + {{(RATIO-1){1'b0}}, 1'b1};

    // A legal mask is a nonzero run of ones starting at lane 0, i.e. 2^n-1:
    // adding one then clears every set bit.
    assign o_legal = (i_keep != '0) && ((i_keep & w_keep_plus1) == '0);

    // Population count of the mask; for a legal mask this is the lane count.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < RATIO; i++) begin
            w_count = w_count + {{(NW-1){1'b0}}, i_keep[i]};
        end
    end

    assign o_nlanes = w_count;

endmodule

// File: rtl/axis_unpack.sv
// rtl/axis_unpack.sv - splits a packed multi-lane stream word into one lane per beat
module axis_unpack #(
    parameter int DSIZE = 16,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DSIZE*RATIO-1:0] s_data,
    input  logic [RATIO-1:0]       s_keep,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DSIZE-1:0]       m_data,
    output logic                   m_last,
    output logic                   err
);

    localparam int IDXW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int NW   = $clog2(RATIO + 1);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t           r_state;
    logic [DSIZE-1:0] r_lanes [RATIO];
    logic [IDXW-1:0]  r_idx;
    logic [NW-1:0]    r_nlanes;
    logic             r_held_last;
    logic             r_err;

    logic             w_legal;
    logic [NW-1:0]    w_nlanes;
    logic             w_at_end;
    logic             w_accept;

    axis_unpack_keepdec #(
        .RATIO (RATIO),
        .NW    (NW)
    ) u_keepdec (
        .i_keep   (s_keep),
        .o_legal  (w_legal),
        .o_nlanes (w_nlanes)
    );

    // The held word is exhausted once the current lane is its last kept lane.
    assign w_at_end = ((NW'(r_idx) + NW'(1)) == r_nlanes);

    // Take a new word when idle, or in the same cycle the last lane leaves so
    // back-to-back words stream without a bubble.
    assign s_ready  = (r_state == EMPTY) || (m_ready && w_at_end);
    assign w_accept = s_valid && s_ready;

    assign m_valid  = (r_state == BUSY);
    assign m_data   = r_lanes[r_idx];
    assign m_last   = r_held_last && w_at_end;
    assign err      = r_err;

    // Control FSM: load legal words, step the lane index, flag malformed keeps.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= EMPTY;
            r_idx       <= '0;
            r_nlanes    <= '0;
            r_held_last <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_state     <= BUSY;
                r_idx       <= '0;
                r_nlanes    <= w_nlanes;
                r_held_last <= s_last;
            end else if ((r_state == BUSY) && m_ready) begin
                if (w_at_end) begin
                    r_state <= EMPTY;
                    r_idx   <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // Lane storage is only meaningful while BUSY, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_legal) begin
            for (int i = 0; i < RATIO; i++) begin
                r_lanes[i] <= s_data[i*DSIZE +: DSIZE];
            end
        end
    end

endmodule

// File: tb/tb_axis_unpack.sv
// tb/tb_axis_unpack.sv - scoreboard bench for axis_unpack
`timescale 1ns/1ps
module tb_axis_unpack;

    localparam int DSIZE = 8;
    localparam int RATIO = 4;

    logic                   clk;
    logic                   resetn;
    logic                   s_valid;
    logic                   s_ready;
    logic [DSIZE*RATIO-1:0] s_data;
    logic [RATIO-1:0]       s_keep;
    logic                   s_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [DSIZE-1:0]       m_data;
    logic                   m_last;
    logic                   err;

    axis_unpack #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_keep  (s_keep),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .err     (err)
    );

    typedef struct {
        logic [DSIZE-1:0] data;
        logic             last;
        logic             wend;
    } lane_t;

    lane_t            sb_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               err_seen = 0;
    int               err_exp  = 0;
    int               ready_mode = 0;
    int               ready_k = 0;
    logic             prev_stall = 1'b0;
    logic [DSIZE-1:0] prev_data;
    logic             prev_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // m_ready driver: mode 0 always ready, mode 1 repeats 1,0,0,1.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                m_ready = (ready_k % 4 == 0) || (ready_k % 4 == 3);
                ready_k++;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Monitor: pop and compare taken lanes, check stall stability and err pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (err) err_seen++;
                if (prev_stall) begin
                    check_eq("stall_valid", {31'd0, m_valid}, 32'd1);
                    check_eq("stall_data", {24'd0, m_data}, {24'd0, prev_data});
                    check_eq("stall_last", {31'd0, m_last}, {31'd0, prev_last});
                end
                if (m_valid && m_ready) begin
                    if (sb_q.size() == 0) begin
                        check_eq("unexpected_lane", {24'd0, m_data}, 32'hFFFF_FFFF);
                    end else begin
                        lane_t e;
                        e = sb_q.pop_front();
                        check_eq("lane_data", {24'd0, m_data}, {24'd0, e.data});
                        check_eq("lane_last", {31'd0, m_last}, {31'd0, e.last});
                        if (e.wend) check_eq("srdy_on_end", {31'd0, s_ready}, 32'd1);
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] data, input logic [3:0] keep, input logic last);
        int n;
        bit ok;
        s_valid = 1'b1;
        s_data  = data;
        s_keep  = keep;
        s_last  = last;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        check_eq("send_accept", {31'd0, ok}, 32'd1);
        case (keep)
            4'h1: n = 1;
            4'h3: n = 2;
            4'h7: n = 3;
            4'hF: n = 4;
            default: n = 0;
        endcase
        if (ok) begin
            if (n == 0) err_exp++;
            for (int i = 0; i < n; i++) begin
                lane_t e;
                e.data = data[i*8 +: 8];
                e.wend = (i == n - 1);
                e.last = last && (i == n - 1);
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(negedge clk);
        check_eq("drain_empty", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit found;
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_keep  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check_eq("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;

        // Full word, single packet.
        send(32'h44332211, 4'hF, 1'b1);
        drain();

        // Back-to-back words with no gap between lanes.
        @(posedge clk);
        #1;
        fork
            begin
                send(32'hDDCCBBAA, 4'hF, 1'b0);
                send(32'h04030201, 4'hF, 1'b1);
            end
            begin
                found = 0;
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk);
                    if (m_valid) begin
                        found = 1;
                        break;
                    end
                end
                check_eq("b2b_start", {31'd0, found}, 32'd1);
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    check_eq("b2b_nogap", {31'd0, m_valid}, 32'd1);
                end
            end
        join
        drain();

        // Partial word followed directly by another word.
        @(posedge clk);
        #1;
        send(32'h00002211, 4'h3, 1'b1);
        send(32'h00776655, 4'h7, 1'b0);
        send(32'h00000099, 4'h1, 1'b1);
        drain();

        // Malformed keeps: nothing emitted, one err pulse each.
        @(posedge clk);
        #1;
        send(32'hDEADBEEF, 4'h5, 1'b1);
        check_eq("bad_srdy0", {31'd0, s_ready}, 32'd1);
        send(32'hCAFEF00D, 4'h0, 1'b1);
        check_eq("bad_srdy1", {31'd0, s_ready}, 32'd1);
        drain();
        check_eq("err_count", err_seen, err_exp);
        check_eq("err_expected2", err_exp, 2);

        // Stalls from m_ready toggling 1,0,0,1.
        @(posedge clk);
        #1;
        ready_k    = 0;
        ready_mode = 1;
        send(32'h8C7B6A59, 4'hF, 1'b1);
        send(32'h00003F2E, 4'h3, 1'b0);
        drain();
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a word.
        send(32'h44332211, 4'hF, 1'b1);
        found = 0;
        for (int t = 0; t < 20; t++) begin
            if (m_valid && m_data == 8'h11) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("mid_rst_saw11", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check_eq("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        check_eq("mid_rst_srdy", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(32'hA4A3A2A1, 4'hF, 1'b1);
        drain();

        check_eq("final_err_count", err_seen, err_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_unpack.md
AXIS_UNPACK -- requirements
Module: axis_unpack

Interface
REQ-001 SHALL have parameter DSIZE, default 16: width of one output lane in bits.
REQ-002 SHALL have parameter RATIO, default 4: lanes per input word; legal range 2..16.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_valid  input  1  input word valid.
REQ-006 SHALL have port s_ready  output  1  input word accepted when s_valid and s_ready are both high.
REQ-007 SHALL have port s_data  input  DSIZE*RATIO  packed lanes, lane 0 in the LSBs.
REQ-008 SHALL have port s_keep  input  RATIO  per-lane valid mask.
REQ-009 SHALL have port s_last  input  1  word ends a packet.
REQ-010 SHALL have port m_valid  output  1  output lane valid.
REQ-011 SHALL have port m_ready  input  1  output lane taken when m_valid and m_ready are both high.
REQ-012 SHALL have port m_data  output  DSIZE  current lane.
REQ-013 SHALL have port m_last  output  1  final lane of a packet.
REQ-014 SHALL have port err  output  1  one-cycle pulse on a malformed keep.

Function
REQ-015 SHALL use two states: EMPTY (no word held) and BUSY (word held, lanes pending).
REQ-016 SHALL treat s_keep as legal only when it is nonzero and contiguous from lane 0 (2^n-1); nlanes = number of set bits.
REQ-017 SHALL, on accepting a legal word, register s_data, nlanes and s_last, reset lane index idx to 0, and enter BUSY.
REQ-018 SHALL, on accepting an illegal keep word, discard it (its s_last included), stay in or return to EMPTY, and pulse err high in the following cycle.
REQ-019 SHALL drive m_valid high exactly while BUSY; m_data = held lane idx; m_last = held_last AND (idx == nlanes-1).
REQ-020 SHALL increment idx on each m_valid and m_ready; at idx == nlanes-1 the held word is exhausted.
REQ-021 SHALL drive s_ready = EMPTY OR (m_ready AND idx == nlanes-1), so a new word loads in the same cycle the last lane leaves.
REQ-022 SHALL give a latency of one cycle: a word accepted at edge t presents lane 0 after edge t.
REQ-023 SHALL sustain one lane per cycle with no bubble between back-to-back words while m_ready is held high.
REQ-024 SHALL hold m_data, m_last and m_valid stable while m_valid is high and m_ready is low.
REQ-025 SHALL return to EMPTY when the last lane leaves and no word is accepted in that cycle.
REQ-026 SHALL never drop a lane or reorder lanes; lanes are emitted lowest index first.

Reset
REQ-027 SHALL, while resetn is low at a clock edge, force EMPTY, idx=0, m_valid=0 and err=0; s_ready then reads 1.
REQ-028 SHALL discard a partially emitted word on reset mid-operation; m_valid is low from the first edge with resetn low.
REQ-029 SHALL leave m_data and the held data unreset (don't-care while m_valid is low).

Structure
REQ-030 SHALL need no shared package; state encoding and the lane-index width clog2(RATIO) are local.
REQ-031 SHALL place keep legality and popcount in one combinational sub-module, axis_unpack_keepdec (in: keep; out: legal, nlanes).

Verification (DSIZE=8, RATIO=4)
REQ-032 Word 0x44332211, keep 0xF, last=1, m_ready=1 -> m_data 11,22,33,44 on four consecutive cycles; m_last only with 44; s_ready high again on the 44 cycle.
REQ-033 Back-to-back words 0xDDCCBBAA then 0x04030201, keep 0xF, m_ready=1 -> eight lanes AA..DD,01..04 with no gap; s_valid held continuously.
REQ-034 Partial word 0x00002211, keep 0x3, last=1 -> 11 then 22 with m_last=1; next word accepted on the 22 cycle.
REQ-035 Keep 0x5, then keep 0x0 -> nothing emitted, err pulses once per bad word, s_ready stays 1.
REQ-036 m_ready toggles 1,0,0,1,... during a full word -> outputs held stable during stalls; lane order preserved; no duplicate lanes.
REQ-037 resetn low for 1 cycle after lane 11 of 0x44332211 -> m_valid 0 at the next edge; a word sent after reset emits from its own lane 0.
